cuda_thread_issue_queue: RTL and testbench

Tagged instruction FIFO sitting directly upstream of a single CUDA thread execution lane in the SM. Accepts PTX instructions from the NoC dispatcher through a valid/ready handshake and issues them one at a time to the thread lane, which latches an instruction whenever it is idle. Tracks the single in-flight instruction and returns its result together with the instruction's tag to writeback.

---
 rtl/agni_sm_pkg.sv | 28 ++
 rtl/agni_sync_fifo.sv | 83 ++++++++
 rtl/cuda_thread_issue_queue.sv | 136 +++++++++++++
 tb/tb_cuda_thread_issue_queue.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/agni_sm_pkg.sv
// +----------------------------------------------------------------------+
// | agni_sm_pkg : shared SM types for thread-lane instruction issue       |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package agni_sm_pkg;

  localparam int OPCODE_W  = 6;
  localparam int PKG_W     = 32;
  localparam int PKG_TAG_W = 4;

  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic                 is_fp;
    logic [PKG_W-1:0]     op1;
    logic [PKG_W-1:0]     op2;
    logic [PKG_TAG_W-1:0] tag;
  } thr_instr_t;

  typedef enum logic [0:0] {
    LANE_IDLE     = 1'b0,
    LANE_INFLIGHT = 1'b1
  } lane_state_e;

endpackage

`default_nettype wire

// File: rtl/agni_sync_fifo.sv
// +----------------------------------------------------------------------+
// | agni_sync_fifo : DEPTH-entry register FIFO with registered head       |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module agni_sync_fifo
  import agni_sm_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type DATA_T = thr_instr_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clr_i,
  input  DATA_T                    wdata_i,
  output DATA_T                    head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  DATA_T             mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              push_ok;
  logic              pop_ok;

  // Self-guarded so an over-push or under-pop can never corrupt count.
  assign push_ok = push_i && !clr_i && (count_q != CNT_W'(DEPTH));
  assign pop_ok  = pop_i  && !clr_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/cuda_thread_issue_queue.sv
// +----------------------------------------------------------------------+
// | cuda_thread_issue_queue : tagged issue FIFO feeding one thread lane   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module cuda_thread_issue_queue
  import agni_sm_pkg::*;
#(
  parameter int W     = PKG_W,
  parameter int DEPTH = 4,
  parameter int TAG_W = PKG_TAG_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPCODE_W-1:0]    in_opcode,
  input  logic                   in_is_fp,
  input  logic [W-1:0]           in_op1,
  input  logic [W-1:0]           in_op2,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   thr_valid,
  output logic [OPCODE_W-1:0]    thr_opcode,
  output logic                   thr_is_fp,
  output logic [W-1:0]           thr_op1,
  output logic [W-1:0]           thr_op2,
  input  logic                   thr_ready,
  input  logic                   thr_done,
  input  logic [W-1:0]           thr_result,
  output logic                   wb_valid,
  output logic [TAG_W-1:0]       wb_tag,
  output logic [W-1:0]           wb_result,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  thr_instr_t        push_data;
  thr_instr_t        head;
  logic              push;
  logic              fire;

  lane_state_e       state_q, state_d;
  logic [TAG_W-1:0]  inflight_tag_q, inflight_tag_d;
  logic              wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
  logic [W-1:0]      wb_result_q, wb_result_d;
  logic              err_q, err_d;

  // Full is judged on the registered count only; a same-cycle pop does not free a slot.
  assign in_ready  = (count < CNT_W'(DEPTH)) && !flush;
  assign push      = in_valid && in_ready;
  assign thr_valid = (count != '0) && (state_q == LANE_IDLE) && !flush;
  assign fire      = thr_valid && thr_ready;

  assign push_data = '{opcode: in_opcode, is_fp: in_is_fp,
                       op1: in_op1, op2: in_op2, tag: in_tag};

  agni_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_T (thr_instr_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (fire),
    .clr_i   (flush),
    .wdata_i (push_data),
    .head_o  (head),
    .count_o (count)
  );

  assign thr_opcode = head.opcode;
  assign thr_is_fp  = head.is_fp;
  assign thr_op1    = head.op1;
  assign thr_op2    = head.op2;

  always_comb begin
    state_d        = state_q;
    inflight_tag_d = inflight_tag_q;
    wb_valid_d     = 1'b0;
    wb_tag_d       = wb_tag_q;
    wb_result_d    = wb_result_q;
    err_d          = err_q;
    case (state_q)
      LANE_IDLE: begin
        if (fire) begin
          state_d        = LANE_INFLIGHT;
          inflight_tag_d = head.tag;
        end
        // A completion with nothing outstanding is a lane protocol error.
        if (thr_done) err_d = 1'b1;
      end
      LANE_INFLIGHT: begin
        if (thr_done) begin
          state_d     = LANE_IDLE;
          wb_valid_d  = 1'b1;
          wb_tag_d    = inflight_tag_q;
          wb_result_d = thr_result;
        end
      end
      default: state_d = LANE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= LANE_IDLE;
      inflight_tag_q <= '0;
      wb_valid_q     <= 1'b0;
      wb_tag_q       <= '0;
      wb_result_q    <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      inflight_tag_q <= inflight_tag_d;
      wb_valid_q     <= wb_valid_d;
      wb_tag_q       <= wb_tag_d;
      wb_result_q    <= wb_result_d;
      err_q          <= err_d;
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_tag    = wb_tag_q;
  assign wb_result = wb_result_q;
  assign err       = err_q;
  assign busy      = (count != '0) || (state_q == LANE_INFLIGHT) || wb_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_cuda_thread_issue_queue.sv
// +----------------------------------------------------------------------+
// | tb_cuda_thread_issue_queue : directed bench for the issue queue       |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_cuda_thread_issue_queue;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [5:0]       in_opcode = '0;
  logic             in_is_fp = 1'b0;
  logic [W-1:0]     in_op1 = '0;
  logic [W-1:0]     in_op2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             thr_valid;
  logic [5:0]       thr_opcode;
  logic             thr_is_fp;
  logic [W-1:0]     thr_op1;
  logic [W-1:0]     thr_op2;
  logic             thr_ready = 1'b0;
  logic             thr_done = 1'b0;
  logic [W-1:0]     thr_result = '0;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [W-1:0]     wb_result;
  logic             flush = 1'b0;
  logic [2:0]       count;
  logic             busy;
  logic             err;

  int checks = 0;
  int passes = 0;

  cuda_thread_issue_queue #(.W(W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_is_fp(in_is_fp),
    .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
    .thr_valid(thr_valid), .thr_opcode(thr_opcode), .thr_is_fp(thr_is_fp),
    .thr_op1(thr_op1), .thr_op2(thr_op2), .thr_ready(thr_ready),
    .thr_done(thr_done), .thr_result(thr_result),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_result(wb_result),
    .flush(flush), .count(count), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [5:0] op, input logic fp,
                          input logic [3:0] tag, input logic [31:0] a, input logic [31:0] b);
    in_valid  = v;
    in_opcode = op;
    in_is_fp  = fp;
    in_tag    = tag;
    in_op1    = a;
    in_op2    = b;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    settle();
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0d exp 1", in_ready); else passes++;
    checks++; if (thr_valid !== 1'b0) $display("FAIL rst_thr_valid: got %0d exp 0", thr_valid); else passes++;
    checks++; if (thr_opcode !== 6'd0 || thr_op1 !== 32'd0 || thr_op2 !== 32'd0 || thr_is_fp !== 1'b0)
      $display("FAIL rst_thr_fields: got op=%0h a=%0h b=%0h fp=%0d exp all 0", thr_opcode, thr_op1, thr_op2, thr_is_fp); else passes++;
    checks++; if (wb_valid !== 1'b0 || wb_tag !== 4'd0 || wb_result !== 32'd0)
      $display("FAIL rst_wb: got v=%0d tag=%0d res=%0h exp 0/0/0", wb_valid, wb_tag, wb_result); else passes++;
    checks++; if (count !== 3'd0 || busy !== 1'b0 || err !== 1'b0)
      $display("FAIL rst_status: got count=%0d busy=%0d err=%0d exp 0/0/0", count, busy, err); else passes++;
  endtask

  task automatic test_single();
    drive_in(1'b1, 6'h01, 1'b0, 4'd3, 32'd3, 32'd4);
    thr_ready = 1'b1;
    settle();
    checks++; if (thr_valid !== 1'b0) $display("FAIL single_no_bypass: got %0d exp 0", thr_valid); else passes++;
    next_cycle();
    drive_in(1'b0, 6'h00, 1'b0, 4'd0, 32'd0, 32'd0);
    settle();
    checks++; if (thr_valid !== 1'b1 || thr_opcode !== 6'h01) $display("FAIL single_issue: got v=%0d op=%0h exp 1/01", thr_valid, thr_opcode); else passes++;
    checks++; if (thr_op1 !== 32'd3 || thr_op2 !== 32'd4) $display("FAIL single_operands: got %0h/%0h exp 3/4", thr_op1, thr_op2); else passes++;
    checks++; if (count !== 3'd1) $display("FAIL single_count: got %0d exp 1", count); else passes++;
    next_cycle();
    thr_ready = 1'b0;
    settle();
    checks++; if (thr_valid !== 1'b0 || count !== 3'd0 || busy !== 1'b1)
      $display("FAIL single_inflight: got v=%0d count=%0d busy=%0d exp 0/0/1", thr_valid, count, busy); else passes++;
    next_cycle();
    thr_done = 1'b1;
    thr_result = 32'h0000_0007;
    next_cycle();
    thr_done = 1'b0;
    thr_ready = 1'b1;
    settle();
    checks++; if (wb_valid !== 1'b1 || wb_tag !== 4'd3 || wb_result !== 32'd7)
      $display("FAIL single_wb: got v=%0d tag=%0d res=%0h exp 1/3/7", wb_valid, wb_tag, wb_result); else passes++;
    next_cycle();
    settle();
    checks++; if (wb_valid !== 1'b0 || wb_tag !== 4'd3 || busy !== 1'b0)
      $display("FAIL single_after: got v=%0d tag=%0d busy=%0d exp 0/3/0", wb_valid, wb_tag, busy); else passes++;
  endtask

  task automatic test_back_to_back();
    thr_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      drive_in(1'b1, 6'h02, 1'b0, 4'(t), 32'(t), 32'(t + 16));
      next_cycle();
    end
    drive_in(1'b1, 6'h02, 1'b0, 4'd4, 32'd4, 32'd20);
    settle();
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) $display("FAIL fill_full: got count=%0d ready=%0d exp 4/0", count, in_ready); else passes++;
    next_cycle();
    drive_in(1'b0, 6'h00, 1'b0, 4'd0, 32'd0, 32'd0);
    settle();
    checks++; if (count !== 3'd4 || thr_op1 !== 32'd0) $display("FAIL fill_refused: got count=%0d head=%0d exp 4/0", count, thr_op1); else passes++;
    thr_ready = 1'b1;
    settle();
    for (int t = 0; t < 4; t++) begin
      checks++; if (thr_valid !== 1'b1 || thr_op1 !== 32'(t) || count !== 3'(4 - t))
        $display("FAIL fill_issue%0d: got v=%0d head=%0d count=%0d exp 1/%0d/%0d", t, thr_valid, thr_op1, count, t, 4 - t); else passes++;
      next_cycle();
      thr_ready = 1'b0;
      settle();
      checks++; if (thr_valid !== 1'b0) $display("FAIL fill_single_fire%0d: got %0d exp 0", t, thr_valid); else passes++;
      thr_done = 1'b1;
      thr_result = 32'(100 + t);
      next_cycle();
      thr_done = 1'b0;
      thr_ready = 1'b1;
      settle();
      checks++; if (wb_valid !== 1'b1 || wb_tag !== 4'(t) || wb_result !== 32'(100 + t))
        $display("FAIL fill_wb%0d: got v=%0d tag=%0d res=%0d exp 1/%0d/%0d", t, wb_valid, wb_tag, wb_result, t, 100 + t); else passes++;
    end
    next_cycle();
    settle();
    checks++; if (count !== 3'd0 || busy !== 1'b0) $display("FAIL fill_drained: got count=%0d busy=%0d exp 0/0", count, busy); else passes++;
  endtask

  task automatic test_wrap();
    int maxc = 0;
    int bad = 0;
    thr_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      drive_in(1'b1, 6'h03, 1'b0, 4'(t), 32'(t), ~32'(t));
      next_cycle();
      drive_in(1'b0, 6'h00, 1'b0, 4'd0, 32'd0, 32'd0);
      settle();
      if (int'(count) > maxc) maxc = int'(count);
      if (thr_op1 !== 32'(t) || thr_op2 !== ~32'(t)) bad++;
      next_cycle();
      thr_done = 1'b1;
      thr_result = 32'(t * 3);
      next_cycle();
      thr_done = 1'b0;
      settle();
      checks++; if (wb_valid !== 1'b1 || wb_tag !== 4'(t) || wb_result !== 32'(t * 3))
        $display("FAIL wrap_wb%0d: got v=%0d tag=%0d res=%0d exp 1/%0d/%0d", t, wb_valid, wb_tag, wb_result, t, t * 3); else passes++;
    end
    checks++; if (bad != 0) $display("FAIL wrap_head: got %0d bad heads exp 0", bad); else passes++;
    checks++; if (maxc > 4 || maxc < 1) $display("FAIL wrap_maxcount: got %0d exp 1..4", maxc); else passes++;
  endtask

  task automatic test_flush();
    thr_ready = 1'b0;
    for (int t = 5; t < 9; t++) begin
      drive_in(1'b1, 6'h04, 1'b0, 4'(t), 32'(t), 32'd0);
      next_cycle();
    end
    drive_in(1'b0, 6'h00, 1'b0, 4'd0, 32'd0, 32'd0);
    thr_ready = 1'b1;
    next_cycle();
    settle();
    checks++; if (count !== 3'd3 || thr_valid !== 1'b0) $display("FAIL flush_pre: got count=%0d v=%0d exp 3/0", count, thr_valid); else passes++;
    flush = 1'b1;
    drive_in(1'b1, 6'h04, 1'b0, 4'd9, 32'd9, 32'd0);
    settle();
    checks++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %0d exp 0", in_ready); else passes++;
    next_cycle();
    flush = 1'b0;
    drive_in(1'b0, 6'h00, 1'b0, 4'd0, 32'd0, 32'd0);
    settle();
    checks++; if (count !== 3'd0 || thr_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL flush_cleared: got count=%0d v=%0d busy=%0d exp 0/0/1", count, thr_valid, busy); else passes++;
    thr_done = 1'b1;
    thr_result = 32'd55;
    next_cycle();
    thr_done = 1'b0;
    settle();
    checks++; if (wb_valid !== 1'b1 || wb_tag !== 4'd5 || wb_result !== 32'd55)
      $display("FAIL flush_wb: got v=%0d tag=%0d res=%0d exp 1/5/55", wb_valid, wb_tag, wb_result); else passes++;
    next_cycle();
    settle();
    checks++; if (thr_valid !== 1'b0 || busy !== 1'b0) $display("FAIL flush_idle: got v=%0d busy=%0d exp 0/0", thr_valid, busy); else passes++;
  endtask

  task automatic test_spurious();
    thr_done = 1'b1;
    thr_result = 32'd99;
    settle();
    checks++; if (err !== 1'b0) $display("FAIL spur_pre_err: got %0d exp 0", err); else passes++;
    next_cycle();
    thr_done = 1'b0;
    settle();
    checks++; if (err !== 1'b1 || wb_valid !== 1'b0 || wb_tag !== 4'd5 || wb_result !== 32'd55)
      $display("FAIL spur_err: got err=%0d v=%0d tag=%0d res=%0d exp 1/0/5/55", err, wb_valid, wb_tag, wb_result); else passes++;
    next_cycle();
    settle();
    checks++; if (err !== 1'b1) $display("FAIL spur_sticky: got %0d exp 1", err); else passes++;
    drive_in(1'b1, 6'h05, 1'b1, 4'd2, 32'h20, 32'h21);
    thr_ready = 1'b1;
    next_cycle();
    drive_in(1'b0, 6'h00, 1'b0, 4'd0, 32'd0, 32'd0);
    settle();
    checks++; if (thr_is_fp !== 1'b1 || thr_opcode !== 6'h05) $display("FAIL spur_fp_head: got fp=%0d op=%0h exp 1/05", thr_is_fp, thr_opcode); else passes++;
    next_cycle();
    thr_done = 1'b1;
    thr_result = 32'h22;
    next_cycle();
    thr_done = 1'b0;
    settle();
    checks++; if (wb_valid !== 1'b1 || wb_tag !== 4'd2 || wb_result !== 32'h22 || err !== 1'b1)
      $display("FAIL spur_follow: got v=%0d tag=%0d res=%0h err=%0d exp 1/2/22/1", wb_valid, wb_tag, wb_result, err); else passes++;
  endtask

  task automatic test_reset_mid();
    thr_ready = 1'b0;
    for (int t = 10; t < 13; t++) begin
      drive_in(1'b1, 6'h06, 1'b0, 4'(t), 32'(t), 32'd1);
      next_cycle();
    end
    drive_in(1'b0, 6'h00, 1'b0, 4'd0, 32'd0, 32'd0);
    thr_ready = 1'b1;
    next_cycle();
    thr_ready = 1'b0;
    settle();
    checks++; if (count !== 3'd2 || busy !== 1'b1) $display("FAIL rmid_pre: got count=%0d busy=%0d exp 2/1", count, busy); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || thr_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL rmid_async: got count=%0d v=%0d ready=%0d busy=%0d exp 0/0/1/0", count, thr_valid, in_ready, busy); else passes++;
    checks++; if (err !== 1'b0 || wb_tag !== 4'd0 || wb_result !== 32'd0 || thr_op1 !== 32'd0)
      $display("FAIL rmid_regs: got err=%0d tag=%0d res=%0h head=%0h exp 0/0/0/0", err, wb_tag, wb_result, thr_op1); else passes++;
    next_cycle();
    rst_n = 1'b1;
    settle();
    drive_in(1'b1, 6'h01, 1'b0, 4'd1, 32'h10, 32'h1);
    thr_ready = 1'b1;
    next_cycle();
    drive_in(1'b0, 6'h00, 1'b0, 4'd0, 32'd0, 32'd0);
    next_cycle();
    thr_ready = 1'b0;
    thr_done = 1'b1;
    thr_result = 32'h11;
    next_cycle();
    thr_done = 1'b0;
    settle();
    checks++; if (wb_valid !== 1'b1 || wb_tag !== 4'd1 || wb_result !== 32'h11)
      $display("FAIL rmid_after: got v=%0d tag=%0d res=%0h exp 1/1/11", wb_valid, wb_tag, wb_result); else passes++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_spurious();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
